// File: rtl/oldland_rf_pkg.sv
// Shared types and constants for the oldland debug register-file arbiter.
package oldland_rf_pkg;

  localparam int unsigned DATA_W               = 32;
  localparam int unsigned SEL_W                = 3;
  localparam int unsigned CNT_W                = 3;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RDCAP = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_e;

  // Register-file write port payload.
  typedef struct packed {
    logic              en;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] val;
  } rf_wr_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/oldland_starve_ctr.sv
// Counts consecutive denied debug cycles and raises a one-cycle pipeline stall
// when the count reaches LIMIT, guaranteeing the debug port a free slot.
module oldland_starve_ctr
  import oldland_rf_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic deny,
  input  logic clear,
  output logic pipe_stall
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = sat_inc(cnt_q);

  // Stall is raised on the same edge the count reaches the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      pipe_stall <= 1'b0;
    end else begin
      pipe_stall <= 1'b0;
      if (clear) begin
        cnt_q <= '0;
      end else if (deny) begin
        cnt_q      <= cnt_inc;
        pipe_stall <= (cnt_inc == CNT_W'(LIMIT));
      end
    end
  end

endmodule

// File: rtl/oldland_rf_arbiter.sv
// Shares the register-file ports between the pipeline and the debug unit,
// granting debug accesses in free slots and forcing a stall when starved.
module oldland_rf_arbiter
  import oldland_rf_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_wr_en,
  input  logic [SEL_W-1:0]  ex_rd_sel,
  input  logic [DATA_W-1:0] ex_wr_val,
  input  logic [SEL_W-1:0]  pipe_ra_sel,
  input  logic [SEL_W-1:0]  pipe_rb_sel,
  input  logic              pipe_rd_en,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [SEL_W-1:0]  dbg_sel,
  input  logic [DATA_W-1:0] dbg_wr_val,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rd_val,
  output logic              pipe_stall,
  output logic [SEL_W-1:0]  rf_ra_sel,
  output logic [SEL_W-1:0]  rf_rb_sel,
  output logic [SEL_W-1:0]  rf_rd_sel,
  output logic              rf_wr_en,
  output logic [DATA_W-1:0] rf_wr_val,
  input  logic [DATA_W-1:0] rf_ra
);

  arb_state_e        state_q, state_d;
  logic              grant;
  logic              deny;
  logic              clear;
  logic              slot_free;
  logic              ack_d;
  logic [DATA_W-1:0] rd_val_d;
  logic              bypass_hit_q, bypass_hit_d;
  logic [DATA_W-1:0] bypass_val_q, bypass_val_d;
  rf_wr_t            wr_port;
  logic [SEL_W-1:0]  ra_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dbg_ack      <= 1'b0;
      dbg_rd_val   <= '0;
      bypass_hit_q <= 1'b0;
      bypass_val_q <= '0;
    end else begin
      state_q      <= state_d;
      dbg_ack      <= ack_d;
      dbg_rd_val   <= rd_val_d;
      bypass_hit_q <= bypass_hit_d;
      bypass_val_q <= bypass_val_d;
    end
  end

  // A registered ack still high means the held request is the one just served.
  always_comb begin
    state_d      = state_q;
    grant        = 1'b0;
    deny         = 1'b0;
    ack_d        = 1'b0;
    rd_val_d     = dbg_rd_val;
    bypass_hit_d = bypass_hit_q;
    bypass_val_d = bypass_val_q;
    wr_port      = '{en: ex_wr_en, sel: ex_rd_sel, val: ex_wr_val};
    ra_sel       = pipe_ra_sel;
    slot_free    = dbg_wr ? (!ex_wr_en || pipe_stall) : (!pipe_rd_en || pipe_stall);

    if (!rst) begin
      unique case (state_q)
        ST_IDLE, ST_WAIT: begin
          if (dbg_req && !dbg_ack) begin
            if (slot_free) begin
              grant = 1'b1;
              if (dbg_wr) begin
                wr_port = '{en: 1'b1, sel: dbg_sel, val: dbg_wr_val};
                ack_d   = 1'b1;
                state_d = ST_ACK;
              end else begin
                ra_sel       = dbg_sel;
                bypass_hit_d = ex_wr_en && (ex_rd_sel == dbg_sel);
                bypass_val_d = ex_wr_val;
                state_d      = ST_RDCAP;
              end
            end else begin
              deny    = 1'b1;
              state_d = ST_WAIT;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RDCAP: begin
          rd_val_d     = bypass_hit_q ? bypass_val_q : rf_ra;
          ack_d        = 1'b1;
          bypass_hit_d = 1'b0;
          state_d      = ST_IDLE;
        end
        ST_ACK: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign clear = grant || (state_d == ST_IDLE);

  oldland_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .deny      (deny),
    .clear     (clear),
    .pipe_stall(pipe_stall)
  );

  assign rf_ra_sel = ra_sel;
  assign rf_rb_sel = pipe_rb_sel;
  assign rf_wr_en  = wr_port.en;
  assign rf_rd_sel = wr_port.sel;
  assign rf_wr_val = wr_port.val;

endmodule

// File: doc/oldland_rf_arbiter.md
OLDLAND_RF_ARBITER -- requirements
Module: oldland_rf_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive denied cycles before the pipeline is stalled for a debug slot.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports ex_wr_en/ex_rd_sel/ex_wr_val  input  1/3/32  pipeline writeback request, never back-pressured.
REQ-005 SHALL have ports pipe_ra_sel/pipe_rb_sel  input  3/3  pipeline read selects; pipe_rd_en  input  1  pipeline uses read ports this cycle.
REQ-006 SHALL have ports dbg_req/dbg_wr/dbg_sel/dbg_wr_val  input  1/1/3/32  debug access request, level-held until ack.
REQ-007 SHALL have ports dbg_ack  output  1  one-cycle completion pulse; dbg_rd_val  output  32  read data.
REQ-008 SHALL have port pipe_stall  output  1  registered one-cycle stall to free regfile ports.
REQ-009 SHALL have ports rf_ra_sel/rf_rb_sel/rf_rd_sel/rf_wr_en/rf_wr_val  output  3/3/3/1/32 to regfile; rf_ra  input  32 from regfile, valid one cycle after select.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT, RDCAP, ACK.
REQ-011 Slot is free when ex_wr_en=0 (write) or pipe_rd_en=0 (read), or pipe_stall=1.
REQ-012 IDLE/WAIT with dbg_req=1 and free slot SHALL grant: write drives rf_wr_en=1, rf_rd_sel=dbg_sel, rf_wr_val=dbg_wr_val, next ACK; read drives rf_ra_sel=dbg_sel, next RDCAP.
REQ-013 Slot not free SHALL enter/stay WAIT, incrementing 3-bit denial counter (saturating).
REQ-014 Counter reaching STARVE_LIMIT SHALL assert pipe_stall next cycle for exactly one cycle; grant SHALL occur in that cycle.
REQ-015 Pipeline contract: ex_wr_en=0 and pipe_rd_en=0 while pipe_stall=1.
REQ-016 Ungranted cycles SHALL pass through pipeline signals: rf_ra_sel=pipe_ra_sel, rf_rb_sel=pipe_rb_sel, rf_wr_en/rd_sel/wr_val from ex_*.
REQ-017 rf_rb_sel SHALL always equal pipe_rb_sel.
REQ-018 RDCAP SHALL register rf_ra into dbg_rd_val, pulse dbg_ack the same cycle, return to IDLE.
REQ-019 Bypass: read grant cycle with ex_wr_en=1 and ex_rd_sel=dbg_sel SHALL return latched ex_wr_val instead of rf_ra.
REQ-020 ACK SHALL pulse dbg_ack for one cycle and return to IDLE; no new grant during ACK or RDCAP.
REQ-021 dbg_req deasserted in WAIT SHALL return to IDLE, no access, counter cleared.
REQ-022 Counter SHALL clear on every grant and in IDLE.
REQ-023 Grant latency: 1 cycle from request (free slot) to read/write grant; ack one cycle after grant.

Reset
REQ-024 rst SHALL force IDLE, counter 0, dbg_ack=0, pipe_stall=0, dbg_rd_val=0, abandon in-flight access without ack.
REQ-025 Ports during reset SHALL be pass-through with rf_wr_en=ex_wr_en.

Structure
REQ-026 FSM state encodings and STARVE_LIMIT default SHALL live in shared package oldland_rf_pkg.
REQ-027 Denial counter/stall generator SHALL be sub-module oldland_starve_ctr; remainder single module.

Verification
REQ-028 Idle pipeline, debug write r3=0xDEADBEEF -> rf_wr_en 1 next cycle, dbg_ack following cycle, later debug read r3 returns 0xDEADBEEF.
REQ-029 pipe_rd_en held 1, debug read r5 -> 4 denials, pipe_stall one cycle, read granted then, ack two cycles later.
REQ-030 Debug read r2 in cycle ex writes r2=0x12345678 with pipe_rd_en=0 -> dbg_rd_val=0x12345678.
REQ-031 rst asserted in RDCAP -> no dbg_ack, IDLE next cycle, outputs at reset values.
REQ-032 dbg_req dropped in WAIT after 2 denials -> no regfile access, no pipe_stall, counter 0.
REQ-033 Assertion throughout: pipe_stall never high two consecutive cycles; dbg_ack never high two consecutive cycles.
